// File: rtl/nanorv32_mem_arb.sv
// Two-port arbiter for nanorv32: instruction fetch and data ports share one
// single-ported 32-bit memory. Grants are combinational and round-robin on
// conflict. Responses come back one cycle after the grant through a one-deep
// response register, so the arbiter can issue one access every cycle.
//
// Response FSM (tracks who owns the data returning this cycle):
//   state    | meaning
//   OWN_NONE | no access was granted last cycle; both rvalid low
//   OWN_IF   | fetch was granted last cycle; fetch port gets the response
//   OWN_D    | data was granted last cycle; data port gets the response
module nanorv32_mem_arb #(
  parameter int AW        = 32,
  parameter int MEM_WORDS = 16384,
  parameter bit D_FIRST   = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         i_req,
  input  logic [AW-1:0]                i_addr,
  output logic                         i_gnt,
  output logic                         i_rvalid,
  output logic [31:0]                  i_rdata,
  output logic                         i_err,

  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [3:0]                   d_be,
  input  logic [AW-1:0]                d_addr,
  input  logic [31:0]                  d_wdata,
  output logic                         d_gnt,
  output logic                         d_rvalid,
  output logic [31:0]                  d_rdata,
  output logic                         d_err,

  output logic                         mem_en,
  output logic [3:0]                   mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata
);

  localparam int MA = $clog2(MEM_WORDS);
  // Word-index limit, sized to the word-index field so the compare is exact
  // even when MEM_WORDS is not a power of two.
  localparam logic [AW-3:0] WORD_LIMIT = (AW-2)'(MEM_WORDS);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // ptr_q = 1 means the data port wins the next conflict.
  logic   ptr_q;
  logic   conflict;
  logic   i_in_range;
  logic   d_in_range;

  owner_t own_q, own_d;
  logic   err_q, err_d;
  logic   wr_q, wr_d;
  logic   rd_ok;

  // Byte-offset bits never select anything in a word-wide memory.
  logic   unused_addr_lsb;
  assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

  assign conflict   = i_req & d_req;
  assign i_in_range = (i_addr[AW-1:2] < WORD_LIMIT);
  assign d_in_range = (d_addr[AW-1:2] < WORD_LIMIT);

  // Arbitration: solo requester always wins; on conflict the pointer decides.
  // Reset blocks all grants so nothing reaches memory while held.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (conflict) begin
        d_gnt = ptr_q;
        i_gnt = ~ptr_q;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  // Round-robin pointer: only a conflict hands priority to the loser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= D_FIRST;
    end else if (conflict) begin
      ptr_q <= ~ptr_q;
    end
  end

  // Memory command for the granted port; out-of-range accesses are granted
  // but never strobe the memory.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (d_gnt) begin
      mem_en    = d_in_range;
      mem_we    = (d_in_range && d_we) ? d_be : 4'b0000;
      mem_addr  = d_addr[MA+1:2];
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_en    = i_in_range;
      mem_addr  = i_addr[MA+1:2];
    end
  end

  // Response FSM state register; reset drops any pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q <= OWN_NONE;
      err_q <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      own_q <= own_d;
      err_q <= err_d;
      wr_q  <= wr_d;
    end
  end

  // Response FSM next state: reloaded every cycle from this cycle's grant.
  always_comb begin
    own_d = OWN_NONE;
    err_d = 1'b0;
    wr_d  = 1'b0;
    if (d_gnt) begin
      own_d = OWN_D;
      err_d = ~d_in_range;
      wr_d  = d_we;
    end else if (i_gnt) begin
      own_d = OWN_IF;
      err_d = ~i_in_range;
    end
  end

  // Response FSM outputs: only the owner sees valid/data/err; memory data
  // passes through only for in-range reads.
  assign rd_ok = ~err_q & ~wr_q;

  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = 32'h0;
    i_err    = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = 32'h0;
    d_err    = 1'b0;
    case (own_q)
      OWN_IF: begin
        i_rvalid = 1'b1;
        i_err    = err_q;
        i_rdata  = rd_ok ? mem_rdata : 32'h0;
      end
      OWN_D: begin
        d_rvalid = 1'b1;
        d_err    = err_q;
        d_rdata  = rd_ok ? mem_rdata : 32'h0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_nanorv32_mem_arb.sv
// Directed bench for nanorv32_mem_arb with a one-cycle-latency memory model.
module tb_nanorv32_mem_arb;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  nanorv32_mem_arb #(.AW(32), .MEM_WORDS(16384), .D_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preloaded while reset is high, byte writes, registered reads.
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (reset) begin
      mem[14'h0040] <= 32'h0000_0013;
      mem[14'h0081] <= 32'h1122_3344;
      mem_rdata     <= 32'h0;
    end else if (mem_en) begin
      if (mem_we != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic prev_d;
    logic exp_d;
    reset = 1'b1; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    prev_d = 1'b0;

    // Reset holds grants and memory strobes low even with requests present.
    @(negedge clk);
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h100; d_we = 1'b1; d_be = 4'hF;
    #1;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_i_err", i_err, 0);
    chk("rst_d_err", d_err, 0);
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; reset = 1'b0;

    // Simple fetch of word 0x40.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100;
    #1;
    chk("f_i_gnt", i_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    chk("f_mem_en", mem_en, 1);
    chk("f_mem_addr", mem_addr, 32'h40);
    chk("f_mem_we", mem_we, 0);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("f_i_rvalid", i_rvalid, 1);
    chk("f_i_rdata", i_rdata, 32'h13);
    chk("f_i_err", i_err, 0);
    chk("f_d_rvalid", d_rvalid, 0);
    @(negedge clk);
    #1;
    chk("f_i_rvalid_once", i_rvalid, 0);

    // Continuous conflict right after reset alternates D,I,D,I...
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h100; d_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_d = ((k % 2) == 0);
      chk("rr_d_gnt", d_gnt, exp_d);
      chk("rr_i_gnt", i_gnt, !exp_d);
      if (k > 0) begin
        chk("rr_d_rvalid", d_rvalid, prev_d);
        chk("rr_i_rvalid", i_rvalid, !prev_d);
      end
      prev_d = exp_d;
      @(negedge clk);
    end
    i_req = 1'b0; d_req = 1'b0;
    #1;
    chk("rr_last_i_rvalid", i_rvalid, 1);
    chk("rr_last_d_rvalid", d_rvalid, 0);
    chk("rr_last_i_rdata", i_rdata, 32'h13);

    // Partial write then back-to-back readback.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h204; d_wdata = 32'hAABB_CCDD;
    #1;
    chk("w_d_gnt", d_gnt, 1);
    chk("w_mem_en", mem_en, 1);
    chk("w_mem_we", mem_we, 4'b0011);
    chk("w_mem_addr", mem_addr, 32'h81);
    chk("w_mem_wdata", mem_wdata, 32'hAABB_CCDD);
    @(negedge clk);
    d_we = 1'b0; d_be = 4'h0;
    #1;
    chk("w_ack_rvalid", d_rvalid, 1);
    chk("w_ack_rdata", d_rdata, 0);
    chk("w_ack_err", d_err, 0);
    chk("r_d_gnt", d_gnt, 1);
    chk("r_mem_we", mem_we, 0);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("r_d_rvalid", d_rvalid, 1);
    chk("r_d_rdata", d_rdata, 32'h1122_CCDD);

    // Out-of-range fetch, then the last in-range word.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h1_0000;
    #1;
    chk("oor_i_gnt", i_gnt, 1);
    chk("oor_mem_en", mem_en, 0);
    @(negedge clk);
    i_addr = 32'hFFFC;
    #1;
    chk("oor_i_rvalid", i_rvalid, 1);
    chk("oor_i_err", i_err, 1);
    chk("oor_i_rdata", i_rdata, 0);
    chk("oor_d_err", d_err, 0);
    chk("top_mem_en", mem_en, 1);
    chk("top_mem_addr", mem_addr, 32'h3FFF);
    @(negedge clk);
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h1_0000; d_wdata = 32'h5555_5555;
    #1;
    chk("top_i_err", i_err, 0);
    chk("oorw_d_gnt", d_gnt, 1);
    chk("oorw_mem_en", mem_en, 0);
    chk("oorw_mem_we", mem_we, 0);
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    #1;
    chk("oorw_d_rvalid", d_rvalid, 1);
    chk("oorw_d_err", d_err, 1);
    chk("oorw_d_rdata", d_rdata, 0);
    chk("oorw_i_rvalid", i_rvalid, 0);

    // Reset during a pending data response; pointer returns to D_FIRST.
    @(negedge clk);
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h100;
    #1;
    chk("pr_conf_d_gnt", d_gnt, 1);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("pr_solo_d_gnt", d_gnt, 1);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("pr_pending", d_rvalid, 1);
    reset = 1'b1;
    #1;
    chk("pr_rst_d_rvalid", d_rvalid, 0);
    chk("pr_rst_d_rdata", d_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("pr_rel_d_rvalid", d_rvalid, 0);
    @(negedge clk);
    #1;
    chk("pr_after_d_rvalid", d_rvalid, 0);
    chk("pr_after_i_rvalid", i_rvalid, 0);
    i_req = 1'b1; d_req = 1'b1;
    #1;
    chk("pr_ptr_d_gnt", d_gnt, 1);
    chk("pr_ptr_i_gnt", i_gnt, 0);

    // Solo fetches leave the pointer alone; data wins the following conflict.
    @(negedge clk); reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk); reset = 1'b0; i_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("solo_i_gnt", i_gnt, 1);
      @(negedge clk);
    end
    d_req = 1'b1;
    #1;
    chk("c1_d_gnt", d_gnt, 1);
    chk("c1_i_gnt", i_gnt, 0);
    @(negedge clk);
    #1;
    chk("c2_i_gnt", i_gnt, 1);
    chk("c2_d_gnt", d_gnt, 0);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("c3_solo_d_gnt", d_gnt, 1);
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nanorv32_mem_arb.md
NANORV32_MEM_ARB -- requirements
Module: nanorv32_mem_arb

Interface
REQ-001 Parameter AW, 32, byte-address width of both requester ports.
REQ-002 Parameter MEM_WORDS, 16384, number of 32-bit words in the shared memory (64 KiB).
REQ-003 Parameter D_FIRST, 1, round-robin pointer reset value; 1 = data port wins the first conflict.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 i_req  input  1  instruction-fetch read request; held with i_addr stable until i_gnt.
REQ-007 i_addr  input  AW  fetch byte address; bits [1:0] ignored.
REQ-008 i_gnt  output  1  fetch request accepted this cycle.
REQ-009 i_rvalid  output  1  fetch response valid, one cycle after i_gnt.
REQ-010 i_rdata  output  32  fetch read data, valid with i_rvalid.
REQ-011 i_err  output  1  fetch address out of range, valid with i_rvalid.
REQ-012 d_req, d_we  input  1, 1  data request, write enable; held stable until d_gnt.
REQ-013 d_be  input  4  write byte enables; ignored when d_we=0.
REQ-014 d_addr, d_wdata  input  AW, 32  data byte address, write data.
REQ-015 d_gnt, d_rvalid, d_err  output  1 each  as for fetch port; d_rvalid also acknowledges writes.
REQ-016 d_rdata  output  32  data read data; 0 on write acknowledges.
REQ-017 mem_en  output  1  memory access strobe.
REQ-018 mem_we  output  4  per-byte write strobes.
REQ-019 mem_addr  output  clog2(MEM_WORDS)  word address.
REQ-020 mem_wdata  output  32  write data; mem_rdata  input  32  read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-021 Grant is combinational from requests and pointer; at most one of i_gnt/d_gnt high per cycle.
REQ-022 Single requester: it is granted the same cycle, independent of pointer.
REQ-023 Both requesting: port indicated by pointer wins; pointer then moves to the other port.
REQ-024 Pointer updates only on a conflict cycle; non-conflict grants leave it unchanged.
REQ-025 Granted request drives mem_addr=addr[clog2(MEM_WORDS)+1:2], mem_wdata, mem_en=1 in the grant cycle.
REQ-026 mem_we = d_be when data port granted with d_we=1, else 4'b0000.
REQ-027 Word index addr[AW-1:2] >= MEM_WORDS is out of range: grant still issued, mem_en=0, mem_we=0.
REQ-028 Response register {owner: NONE/IFETCH/DATA, err, was_write} loads each cycle from the grant.
REQ-029 Cycle after a grant: owning port rvalid=1 for exactly one cycle; other port rvalid=0.
REQ-030 rdata = mem_rdata for in-range reads; 0 for writes and out-of-range accesses.
REQ-031 err=1 only for out-of-range responses; 0 otherwise.
REQ-032 Back-to-back grants allowed every cycle (full throughput, one access per cycle, pipelined one deep).
REQ-033 Non-owning port rdata=0 and err=0.
REQ-034 No request queuing; requester holding req without grant is not recorded.

Reset
REQ-035 reset asserted: owner=NONE, pointer=D_FIRST, i_rvalid=d_rvalid=0, i_err=d_err=0, rdata outputs 0, asynchronously.
REQ-036 While reset high: i_gnt=d_gnt=0, mem_en=0, mem_we=0 regardless of requests.
REQ-037 Reset during a pending response discards it; no rvalid after reset deasserts.
REQ-038 First cycle after reset release arbitrates normally.

Verification
REQ-039 Fetch only, i_addr=0x100, mem word 0x40=0x00000013 -> i_gnt cycle N, mem_addr=0x40, i_rvalid cycle N+1, i_rdata=0x00000013, i_err=0.
REQ-040 Both request continuously after reset, D_FIRST=1 -> grants D,I,D,I...; each rvalid follows its grant by one cycle.
REQ-041 Data write d_addr=0x204, d_be=4'b0011, d_wdata=0xAABBCCDD, then read 0x204 (old word 0x11223344) -> mem_we=4'b0011 on write, d_rvalid with d_rdata=0 on ack, readback 0x1122CCDD.
REQ-042 Fetch i_addr=0x10000 (MEM_WORDS=16384) -> i_gnt=1, mem_en=0, next cycle i_rvalid=1, i_err=1, i_rdata=0.
REQ-043 Reset asserted in cycle after d_gnt -> d_rvalid stays 0, pointer back to D_FIRST, no spurious rvalid after release.
REQ-044 Fetch-only for 5 cycles then conflict -> pointer unchanged by solo grants; data wins conflict (D_FIRST=1).
